// File: rtl/channel_scheduler.sv
// -----------------------------------------------------------------------------
// channel_scheduler
//
// Grants one of eight request channels at a time. IDs 7..5 form a high
// class arbitrated by fixed priority (7 > 6 > 5). IDs 4..0 form a low class
// arbitrated round-robin whenever no high-class request is present. A grant
// is held until the owner signals done, drops its request, or MAX_HOLD
// cycles elapse. The grant is never preempted. Every grant is followed by a
// one-cycle GAP and then at least one IDLE cycle before the next grant.
//
// Parameters
//   MAX_HOLD      maximum number of cycles one grant may be held (2..256)
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   req[7:0]      level-sensitive request per channel ID (bit n = ID n)
//   done          granted channel finished; only looked at while holding
//   grant_valid   a grant is active this cycle
//   grant_id      granted ID, 0 when no grant is active
//   grant_onehot  one-hot form of grant_id, all zero when no grant is active
//   timeout       one-cycle pulse in GAP after a grant expired at MAX_HOLD
//   busy          high whenever the scheduler is not IDLE
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module channel_scheduler #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic [7:0] grant_onehot,
  output logic       timeout,
  output logic       busy
);

  // Hold counter is wide enough for 0..MAX_HOLD-1; the grant always ends at
  // MAX_HOLD-1, so the counter never has to wrap.
  localparam int               CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Round-robin pointer value after reset: the search starts at ID 4.
  localparam logic [2:0] RR_START = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state,  state_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [2:0]       rr_ptr, rr_ptr_d;

  logic             grant_valid_d;
  logic [2:0]       grant_id_d;
  logic [7:0]       grant_onehot_d;
  logic             timeout_d;
  logic             busy_d;

  // Arbitration result for the current request vector.
  logic [2:0]       win_id;
  logic             win_low;

  // Grant termination conditions while holding.
  logic             expired;
  logic             owner_dropped;
  logic             hold_end;

  // ---------------------------------------------------------------------------
  // Low-class round-robin search: start at ptr, walk downward, wrap 0 -> 4.
  // Only consulted when at least one of req[4:0] is set.
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    idx     = ptr;
    for (int i = 0; i < 5; i++) begin
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (idx == 3'd0) ? 3'd4 : idx - 3'd1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Winner selection: high class by fixed priority, else low-class round-robin.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_id  = '0;
    win_low = 1'b0;
    if (req[7]) begin
      win_id = 3'd7;
    end else if (req[6]) begin
      win_id = 3'd6;
    end else if (req[5]) begin
      win_id = 3'd5;
    end else begin
      win_low = 1'b1;
      win_id  = rr_pick(req, rr_ptr);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state;
    hold_cnt_d     = hold_cnt;
    rr_ptr_d       = rr_ptr;
    grant_valid_d  = grant_valid;
    grant_id_d     = grant_id;
    grant_onehot_d = grant_onehot;
    timeout_d      = 1'b0;

    expired        = (hold_cnt == HOLD_LAST);
    owner_dropped  = !req[grant_id];
    hold_end       = done || owner_dropped || expired;

    unique case (state)
      IDLE: begin
        if (req != 8'h00) begin
          state_d        = HOLD;
          grant_valid_d  = 1'b1;
          grant_id_d     = win_id;
          grant_onehot_d = 8'b1 << win_id;
          hold_cnt_d     = '0;
          // Only low-class grants advance the pointer, to just below the winner.
          if (win_low) begin
            rr_ptr_d = (win_id == 3'd0) ? RR_START : win_id - 3'd1;
          end
        end
      end

      HOLD: begin
        if (hold_end) begin
          state_d        = GAP;
          grant_valid_d  = 1'b0;
          grant_id_d     = '0;
          grant_onehot_d = '0;
          hold_cnt_d     = '0;
          // A timeout is reported only when expiry is the sole reason to stop.
          timeout_d      = expired && !done && !owner_dropped;
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d        = IDLE;
        grant_valid_d  = 1'b0;
        grant_id_d     = '0;
        grant_onehot_d = '0;
        hold_cnt_d     = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: reset is asynchronous, so a grant is dropped the instant rst_n
  // falls, without waiting for a clock edge and without a timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      rr_ptr       <= RR_START;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_cnt_d;
      rr_ptr       <= rr_ptr_d;
      grant_valid  <= grant_valid_d;
      grant_id     <= grant_id_d;
      grant_onehot <= grant_onehot_d;
      timeout      <= timeout_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_channel_scheduler
//
// Directed scenarios followed by randomized traffic. A behavioural model
// tracks the current owner, how long it has held the grant, the cooldown
// after a grant and the round-robin start point, and predicts every output
// after each rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_channel_scheduler;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [7:0] grant_onehot;
  logic       timeout;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int   m_owner;   // granted ID, -1 when none
  int   m_held;    // cycles the current owner has held the grant
  bit   m_gap;     // in the one-cycle cooldown right after a grant
  bit   m_to;      // timeout pulse expected this cycle
  int   m_ptr;     // low-class round-robin start ID

  channel_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
    m_ptr   = 4;
  endtask

  function automatic int model_pick(input logic [7:0] r);
    if (r[7]) return 7;
    if (r[6]) return 6;
    if (r[5]) return 5;
    for (int i = 0; i < 5; i++) begin
      int idx;
      idx = (m_ptr - i + 5) % 5;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // One rising edge with the currently driven req/done.
  task automatic model_step();
    int w;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (done || !req[m_owner] || m_held == MAX_HOLD) begin
        m_to    = (m_held == MAX_HOLD) && !done && req[m_owner];
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req != 8'h00) begin
      w       = model_pick(req);
      m_owner = w;
      m_held  = 0;
      if (w < 5) m_ptr = (w + 4) % 5;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic       e_gv;
    logic [2:0] e_id;
    logic [7:0] e_oh;
    e_gv = (m_owner >= 0);
    e_id = e_gv ? 3'(m_owner) : 3'd0;
    e_oh = e_gv ? (8'h01 << m_owner) : 8'h00;
    chk({tag, "_grant_valid"},  {31'd0, grant_valid}, {31'd0, e_gv});
    chk({tag, "_grant_id"},     {29'd0, grant_id},    {29'd0, e_id});
    chk({tag, "_grant_onehot"}, {24'd0, grant_onehot}, {24'd0, e_oh});
    chk({tag, "_timeout"},      {31'd0, timeout},     {31'd0, m_to});
    chk({tag, "_busy"},         {31'd0, busy},        {31'd0, (e_gv || m_gap)});
  endtask

  // Drive inputs on the falling edge, clock once, check on the next falling edge.
  task automatic cycle(input logic [7:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Assert reset between edges, check outputs clear before the next edge,
  // keep it across one edge and release it on the following falling edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs({tag, "_async"});
    chk({tag, "_async_gv_zero"}, {31'd0, grant_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs({tag, "_held"});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int         gq[$];
  int         gaps[$];
  int         zeros;
  logic       prev_gv;
  int         hi;
  logic [7:0] rnd_req;
  logic       rnd_done;
  int         exp26[6];

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    chk("reset_onehot_zero", {24'd0, grant_onehot}, 32'd0);
    rst_n = 1'b1;

    // Low-class rotation with done pulsed in every hold cycle.
    exp26   = '{4, 3, 2, 1, 0, 4};
    prev_gv = 1'b0;
    zeros   = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(8'h1F, 1'b1, "rot");
      if (grant_valid) begin
        if (!prev_gv) begin
          gq.push_back(int'(grant_id));
          if (gq.size() > 1) gaps.push_back(zeros);
        end
        zeros = 0;
      end else begin
        zeros++;
      end
      prev_gv = grant_valid;
    end
    chk("rot_grant_count", {31'd0, (gq.size() >= 6)}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size()) chk($sformatf("rot_id%0d", i), 32'(gq[i]), 32'(exp26[i]));
    end
    for (int i = 0; i < 5; i++) begin
      if (i < gaps.size()) chk($sformatf("rot_gap%0d", i), 32'(gaps[i]), 32'd2);
    end
    cycle(8'h00, 1'b0, "rot_idle");
    cycle(8'h00, 1'b0, "rot_idle");

    // High class wins; dropping the owner's request ends the grant.
    async_reset("hi_rst");
    cycle(8'hE1, 1'b0, "hi_g7");
    chk("hi_id7", {29'd0, grant_id}, 32'd7);
    cycle(8'h61, 1'b0, "hi_drop");
    chk("hi_gap_gv", {31'd0, grant_valid}, 32'd0);
    cycle(8'h61, 1'b0, "hi_idle");
    chk("hi_idle_gv", {31'd0, grant_valid}, 32'd0);
    cycle(8'h61, 1'b0, "hi_g6");
    chk("hi_id6", {29'd0, grant_id}, 32'd6);
    cycle(8'h00, 1'b1, "hi_end");
    cycle(8'h00, 1'b0, "hi_idle2");
    cycle(8'h1F, 1'b0, "hi_ptr");
    chk("hi_ptr_still4", {29'd0, grant_id}, 32'd4);
    cycle(8'h00, 1'b1, "hi_end2");
    cycle(8'h00, 1'b0, "hi_idle3");

    // Hold expiry raises timeout in GAP, then the same channel is regranted.
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(8'h08, 1'b0, "exp_hold");
      hi += int'(grant_valid);
    end
    chk("exp_hold_cycles", 32'(hi), 32'd4);
    cycle(8'h08, 1'b0, "exp_gap");
    chk("exp_gap_gv", {31'd0, grant_valid}, 32'd0);
    chk("exp_gap_timeout", {31'd0, timeout}, 32'd1);
    cycle(8'h08, 1'b0, "exp_idle");
    chk("exp_idle_timeout", {31'd0, timeout}, 32'd0);
    cycle(8'h08, 1'b0, "exp_regrant");
    chk("exp_regrant_id", {29'd0, grant_id}, 32'd3);
    chk("exp_regrant_gv", {31'd0, grant_valid}, 32'd1);

    // done in the final hold cycle suppresses timeout.
    cycle(8'h08, 1'b0, "sup_h2");
    cycle(8'h08, 1'b0, "sup_h3");
    cycle(8'h08, 1'b0, "sup_h4");
    chk("sup_h4_gv", {31'd0, grant_valid}, 32'd1);
    cycle(8'h08, 1'b1, "sup_gap");
    chk("sup_gap_gv", {31'd0, grant_valid}, 32'd0);
    chk("sup_gap_timeout", {31'd0, timeout}, 32'd0);
    cycle(8'h00, 1'b0, "sup_idle");

    // Reset in the middle of a grant to ID 2.
    cycle(8'h04, 1'b0, "mr_g2");
    chk("mr_id2", {29'd0, grant_id}, 32'd2);
    cycle(8'h04, 1'b0, "mr_hold");
    async_reset("mr_rst");
    chk("mr_timeout_zero", {31'd0, timeout}, 32'd0);
    cycle(8'h01, 1'b0, "mr_g0");
    chk("mr_id0", {29'd0, grant_id}, 32'd0);
    chk("mr_g0_gv", {31'd0, grant_valid}, 32'd1);
    cycle(8'h00, 1'b1, "mr_end");
    cycle(8'h00, 1'b0, "mr_idle");
    cycle(8'h1F, 1'b0, "mr_ptr");
    chk("mr_ptr_back4", {29'd0, grant_id}, 32'd4);
    cycle(8'h00, 1'b1, "mr_end2");

    // Randomized traffic, with occasional resets.
    rnd_req = 8'h00;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       rnd_req = 8'h00;
        1:       rnd_req = 8'($urandom) & 8'h1F;
        2:       rnd_req = rnd_req;
        default: rnd_req = 8'($urandom);
      endcase
      rnd_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle(rnd_req, rnd_done, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/channel_scheduler.md
CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning maximum cycles one grant may be held (legal 2..256).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port req  input  8  request per channel ID; bit n = ID n; level-sensitive.
REQ-005 SHALL have port done  input  1  granted channel finished transfer; sampled only in HOLD.
REQ-006 SHALL have port grant_valid  output  1  a grant is active this cycle.
REQ-007 SHALL have port grant_id  output  3  granted ID; 0 when grant_valid=0.
REQ-008 SHALL have port grant_onehot  output  8  one-hot of grant_id; all zero when grant_valid=0.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD, GAP; all outputs registered.
REQ-012 IDLE: if req!=0 at an edge, SHALL latch winner into grant_id, set grant_valid=1, clear hold counter, enter HOLD at that edge (1-cycle request-to-grant latency); if req==0, remain IDLE.
REQ-013 Winner SHALL be fixed priority for high class: ID7 > ID6 > ID5.
REQ-014 If req[7:5]==0, winner SHALL be chosen among req[4:0] round-robin: search starts at rr_ptr, descends, wraps 0->4.
REQ-015 rr_ptr SHALL reset to 4; after a low-class grant to ID k SHALL become k-1 (k=0 -> 4); high-class grants SHALL NOT change rr_ptr.
REQ-016 HOLD: grant_valid, grant_id, grant_onehot SHALL remain constant; hold counter increments by 1 each HOLD cycle, width clog2(MAX_HOLD), no wrap.
REQ-017 HOLD SHALL exit to GAP at the edge where done=1, or req[grant_id]=0, or hold counter equals MAX_HOLD-1.
REQ-018 timeout SHALL pulse for exactly the GAP cycle following an expiry-only exit; done=1 or request drop in the expiry cycle SHALL suppress timeout.
REQ-019 No preemption: requests arriving during HOLD, including ID7, SHALL wait until the grant ends.
REQ-020 GAP: grant_valid=0, grant_id=0, grant_onehot=0 for exactly one cycle; next state IDLE unconditionally (min two idle cycles between grants).
REQ-021 done asserted outside HOLD SHALL be ignored.
REQ-022 grant_onehot SHALL equal 1<<grant_id whenever grant_valid=1.
REQ-023 Requests need not be held: a req dropped while waiting is simply not considered; no request queuing.

Reset
REQ-024 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, grant_valid=0, grant_id=0, grant_onehot=0, timeout=0, busy=0, hold counter=0, rr_ptr=4.
REQ-025 Reset asserted mid-HOLD SHALL drop grant the same instant with no timeout pulse; first arbitration occurs at first rising edge with rst_n=1 and req!=0.

Verification
REQ-026 req=8'h1F constant, done pulsed each HOLD cycle -> grant_id sequence 4,3,2,1,0,4 with 2 idle cycles between grants.
REQ-027 req=8'hE1 -> grant_id=7; during HOLD drop req[7], keep others -> GAP, IDLE, then grant_id=6; rr_ptr still 4.
REQ-028 MAX_HOLD=4, req=8'h08 held, done=0 -> grant_valid high 4 cycles, timeout pulse 1 cycle in GAP, then regrant ID3.
REQ-029 MAX_HOLD=4, done=1 in the 4th HOLD cycle -> exit to GAP, timeout stays 0.
REQ-030 Grant ID2 active, rst_n=0 mid-cycle -> outputs zero before next edge; after release with req=8'h01 -> grant_id=0 one edge later, rr_ptr becomes 4.
